sdram_rsp_model: RTL and testbench
==================================

SDRAM_RSP_MODEL -- requirements
Module: sdram_rsp_model

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- sdram_clk  in  1  sole clock; all state changes on its rising edge.
- sdram_rst  in  1  reset, synchronous, active-high.
- sdr_cs_n  in  1  chip select; high means NOP.
- sdr_ras_n, sdr_cas_n, sdr_we_n  in  1 each  command strobes.
- sdr_ba  in  2  bank address.
- sdr_addr  in  13  row (ACTIVE), column (READ/WRITE), addr[10] all-bank flag (PRECHARGE), mode field (LOAD MODE).
- sdr_dqm  in  2  write byte mask; bit1 = [15:8], bit0 = [7:0]; ignored on reads.
- sdr_din  in  16  write data from controller.
- sdr_dout  out  16  read data.
- sdr_den  out  1  read data valid / drive enable.
- rsp_st  out  2  responder FSM state, exported for coverage.
- proto_err  out  1  one-cycle pulse on an illegal command.

REQ-002 Command decode SHALL apply only when sdr_cs_n=0, with {ras_n,cas_n,we_n}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE.

Function
REQ-003 Storage SHALL be 1024x16, indexed {ba, open_row[1:0], col[5:0]}; higher row and column bits SHALL be ignored, so those addresses alias.
REQ-004 The block SHALL track one open/closed flag and a 2-bit open row per bank.
REQ-005 ACTIVE to a closed bank SHALL open it and latch sdr_addr[1:0]; ACTIVE to an open bank SHALL be an error.
REQ-006 PRECHARGE SHALL close bank sdr_ba, or all banks when addr[10]=1; precharging a closed bank SHALL be legal and a no-op.
REQ-007 LOAD MODE SHALL set burst length from addr[2:0] (0=1, 1=2, 2=4, 3=8) and CAS latency from addr[6:4] (2 or 3).
REQ-008 LOAD MODE with any other field value, or with any bank open, SHALL be an error and SHALL leave the mode unchanged.
REQ-009 rsp_st encoding SHALL be 00 IDLE, 01 WRITE, 10 READ, 11 REFRESH.
REQ-010 A WRITE to an open bank SHALL store sdr_din at the same edge, masked per sdr_dqm; state SHALL go to WRITE if BL>1.
REQ-011 The remaining BL-1 write beats SHALL be taken on the following edges, one per edge.
REQ-012 A READ to an open bank SHALL start a burst; each beat SHALL be visible on sdr_dout with sdr_den=1 at edge N+CL, where N is the edge at which the beat was issued.
REQ-013 Read beats SHALL be issued on consecutive edges through a CL-deep pipeline, with state READ while beats are being issued.
REQ-014 The burst column SHALL increment sequentially and wrap within the BL-aligned block (BL=4, start col 6: 6,7,4,5).
REQ-015 A READ, WRITE, PRECHARGE or BURST TERMINATE arriving during a burst SHALL stop further beats of the old burst.
REQ-016 Read beats already in the CAS pipeline SHALL still be delivered.
REQ-017 A new READ or WRITE that interrupts a burst SHALL start its own burst at the same edge.
REQ-018 A WRITE command SHALL take priority over a write beat pending in the same cycle.
REQ-019 sdr_den SHALL be 0 and sdr_dout SHALL hold 0 whenever no read beat is valid.
REQ-020 AUTO REFRESH with all banks closed SHALL enter REFRESH for exactly 7 cycles, then return to IDLE.
REQ-021 AUTO REFRESH with any bank open SHALL be an error.
REQ-022 Any non-NOP command during REFRESH SHALL be an error.
REQ-023 READ or WRITE to a closed bank SHALL be an error.
REQ-024 Each error SHALL pulse proto_err for one cycle, and the offending command SHALL have no other effect.
REQ-025 The state SHALL return to IDLE after the last beat issued, unless a new command has started another burst.

Reset
REQ-026 While sdram_rst=1 at an edge, the block SHALL close all banks, set CL=3 and BL=1, flush the read pipeline, and drive sdr_den=0, sdr_dout=0, rsp_st=00 and proto_err=0.
REQ-027 A reset asserted mid-burst or mid-refresh SHALL abort that activity at that edge, with no further beats.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-029 The bench SHALL cover the following directed scenarios.
- Mode BL=4/CL=2; ACTIVE ba=1 row=2; WRITE col=4 with data A0..A3, dqm=0 -> READ col=4 returns A0..A3 at edges N+2..N+5, rsp_st=10 for 4 cycles.
- BL=4, WRITE col=6 with D0..D3; READ col=4 -> returns D2,D3,D0,D1 (wrap check).
- BL=8/CL=3 READ, then BURST TERMINATE 2 edges later -> exactly 2 beats, sdr_den high for 2 cycles starting at edge N+3.
- WRITE 16'hFFFF with dqm=2'b10 over existing 16'h1234 -> reads back 16'h12FF.
- READ to closed bank, ACTIVE to open bank, AUTO REFRESH with a bank open, READ during REFRESH -> one proto_err pulse each, memory and state unchanged.
- Assert sdram_rst 1 cycle mid CL=3 read burst -> sdr_den=0 from the next edge, CL=3/BL=1 restored, earlier written data still readable after re-ACTIVE.

Source files
------------

// File: rtl/sdram_rsp_model.sv
// rtl/sdram_rsp_model.sv - behavioural SDRAM responder: bank tracking, bursts, CAS pipeline
// Four banks with one open row each, 1Kx16 aliased storage, and illegal-command flagging.
module sdram_rsp_model (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic        sdr_cs_n,
  input  logic        sdr_ras_n,
  input  logic        sdr_cas_n,
  input  logic        sdr_we_n,
  input  logic [1:0]  sdr_ba,
  input  logic [12:0] sdr_addr,
  input  logic [1:0]  sdr_dqm,
  input  logic [15:0] sdr_din,
  output logic [15:0] sdr_dout,
  output logic        sdr_den,
  output logic [1:0]  rsp_st,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WRITE   = 2'b01,
    ST_READ    = 2'b10,
    ST_REFRESH = 2'b11
  } st_e;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  st_e              st_q, st_d;
  logic [3:0]       bank_open_q, bank_open_d;
  logic [3:0][1:0]  open_row_q, open_row_d;
  logic [1:0]       bl_code_q, bl_code_d;
  logic             cl3_q, cl3_d;
  logic [2:0]       rem_q, rem_d;
  logic [2:0]       ref_cnt_q, ref_cnt_d;
  logic [1:0]       bst_ba_q, bst_ba_d;
  logic [5:0]       bst_col_q, bst_col_d;
  logic [2:0]       bst_off_q, bst_off_d;
  logic [2:0]       pipe_vld_q, pipe_vld_d;
  logic [2:0][15:0] pipe_dat_q, pipe_dat_d;
  logic             den_q, den_d;
  logic [15:0]      dout_q, dout_d;
  logic             err_q, err_d;

  logic [15:0]      mem [1024];

  cmd_e             cmd;
  logic [5:0]       bl_mask;
  logic [9:0]       beat_addr;
  logic [9:0]       cmd_addr;
  logic             mem_we;
  logic [1:0]       mem_mask;
  logic [9:0]       mem_addr;
  logic             rd_issue;
  logic [9:0]       rd_addr;
  logic             unused_addr_bits;

  function automatic logic [5:0] beat_col(input logic [5:0] start, input logic [2:0] off,
                                          input logic [5:0] mask);
    logic [5:0] sum;
    sum = start + {3'b000, off};
    return (start & ~mask) | (sum & mask);
  endfunction

  assign cmd              = cmd_e'({sdr_ras_n, sdr_cas_n, sdr_we_n});
  assign beat_addr        = {bst_ba_q, open_row_q[bst_ba_q], beat_col(bst_col_q, bst_off_q, bl_mask)};
  assign cmd_addr         = {sdr_ba, open_row_q[sdr_ba], sdr_addr[5:0]};
  assign unused_addr_bits = ^{sdr_addr[12:11], sdr_addr[9:7]};

  always_comb begin
    bl_mask = 6'd0;
    case (bl_code_q)
      2'd0:    bl_mask = 6'd0;
      2'd1:    bl_mask = 6'd1;
      2'd2:    bl_mask = 6'd3;
      default: bl_mask = 6'd7;
    endcase
  end

  // Burst continuation is computed first; a legal command below overrides it.
  always_comb begin
    st_d        = st_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    bl_code_d   = bl_code_q;
    cl3_d       = cl3_q;
    rem_d       = rem_q;
    ref_cnt_d   = ref_cnt_q;
    bst_ba_d    = bst_ba_q;
    bst_col_d   = bst_col_q;
    bst_off_d   = bst_off_q;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_mask    = 2'b00;
    mem_addr    = 10'd0;
    rd_issue    = 1'b0;
    rd_addr     = 10'd0;

    case (st_q)
      ST_READ: begin
        if (rem_q != 3'd0) begin
          rd_issue  = 1'b1;
          rd_addr   = beat_addr;
          rem_d     = rem_q - 3'd1;
          bst_off_d = bst_off_q + 3'd1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (rem_q != 3'd0) begin
          mem_we    = 1'b1;
          mem_mask  = sdr_dqm;
          mem_addr  = beat_addr;
          rem_d     = rem_q - 3'd1;
          bst_off_d = bst_off_q + 3'd1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (ref_cnt_q == 3'd0) st_d = ST_IDLE;
        else                   ref_cnt_d = ref_cnt_q - 3'd1;
      end
      default: ;
    endcase

    if (st_q == ST_REFRESH) begin
      if (!sdr_cs_n && cmd != CMD_NOP) err_d = 1'b1;
    end else if (!sdr_cs_n) begin
      case (cmd)
        CMD_ACT: begin
          if (bank_open_q[sdr_ba]) begin
            err_d = 1'b1;
          end else begin
            bank_open_d[sdr_ba] = 1'b1;
            open_row_d[sdr_ba]  = sdr_addr[1:0];
          end
        end
        CMD_RD: begin
          if (!bank_open_q[sdr_ba]) begin
            err_d = 1'b1;
          end else begin
            mem_we    = 1'b0;
            rd_issue  = 1'b1;
            rd_addr   = cmd_addr;
            st_d      = ST_READ;
            rem_d     = bl_mask[2:0];
            bst_ba_d  = sdr_ba;
            bst_col_d = sdr_addr[5:0];
            bst_off_d = 3'd1;
          end
        end
        CMD_WR: begin
          if (!bank_open_q[sdr_ba]) begin
            err_d = 1'b1;
          end else begin
            rd_issue  = 1'b0;
            mem_we    = 1'b1;
            mem_mask  = sdr_dqm;
            mem_addr  = cmd_addr;
            st_d      = (bl_code_q != 2'd0) ? ST_WRITE : ST_IDLE;
            rem_d     = bl_mask[2:0];
            bst_ba_d  = sdr_ba;
            bst_col_d = sdr_addr[5:0];
            bst_off_d = 3'd1;
          end
        end
        CMD_PRE, CMD_BST: begin
          if (cmd == CMD_PRE) begin
            if (sdr_addr[10]) bank_open_d         = 4'b0000;
            else              bank_open_d[sdr_ba] = 1'b0;
          end
          rd_issue = 1'b0;
          mem_we   = 1'b0;
          rem_d    = 3'd0;
          st_d     = ST_IDLE;
        end
        CMD_REF: begin
          if (|bank_open_q) begin
            err_d = 1'b1;
          end else begin
            st_d      = ST_REFRESH;
            ref_cnt_d = 3'd6;
          end
        end
        CMD_LMR: begin
          if ((|bank_open_q) || sdr_addr[2] ||
              (sdr_addr[6:4] != 3'd2 && sdr_addr[6:4] != 3'd3)) begin
            err_d = 1'b1;
          end else begin
            bl_code_d = sdr_addr[1:0];
            cl3_d     = sdr_addr[4];
          end
        end
        default: ;
      endcase
    end
  end

  // CL=2 beats enter one stage later so every beat leaves through the same output register.
  always_comb begin
    pipe_vld_d = {pipe_vld_q[1:0], 1'b0};
    pipe_dat_d = {pipe_dat_q[1:0], 16'h0000};
    if (rd_issue) begin
      if (cl3_q) begin
        pipe_vld_d[0] = 1'b1;
        pipe_dat_d[0] = mem[rd_addr];
      end else begin
        pipe_vld_d[1] = 1'b1;
        pipe_dat_d[1] = mem[rd_addr];
      end
    end
    den_d  = pipe_vld_q[2];
    dout_d = pipe_vld_q[2] ? pipe_dat_q[2] : 16'h0000;
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      st_q        <= ST_IDLE;
      bank_open_q <= 4'b0000;
      open_row_q  <= '0;
      bl_code_q   <= 2'd0;
      cl3_q       <= 1'b1;
      rem_q       <= 3'd0;
      ref_cnt_q   <= 3'd0;
      bst_ba_q    <= 2'd0;
      bst_col_q   <= 6'd0;
      bst_off_q   <= 3'd0;
      pipe_vld_q  <= 3'b000;
      pipe_dat_q  <= '0;
      den_q       <= 1'b0;
      dout_q      <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      bl_code_q   <= bl_code_d;
      cl3_q       <= cl3_d;
      rem_q       <= rem_d;
      ref_cnt_q   <= ref_cnt_d;
      bst_ba_q    <= bst_ba_d;
      bst_col_q   <= bst_col_d;
      bst_off_q   <= bst_off_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_dat_q  <= pipe_dat_d;
      den_q       <= den_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
    end
  end

  // Storage survives reset; only the write strobe is suppressed while reset is held.
  always_ff @(posedge sdram_clk) begin
    if (mem_we && !sdram_rst) begin
      if (!mem_mask[1]) mem[mem_addr][15:8] <= sdr_din[15:8];
      if (!mem_mask[0]) mem[mem_addr][7:0]  <= sdr_din[7:0];
    end
  end

  assign sdr_dout  = dout_q;
  assign sdr_den   = den_q;
  assign rsp_st    = st_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_sdram_rsp_model.sv
// tb/tb_sdram_rsp_model.sv - scoreboard bench for sdram_rsp_model
module tb_sdram_rsp_model;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst = 1'b1;
  logic        sdr_cs_n  = 1'b1;
  logic        sdr_ras_n = 1'b1;
  logic        sdr_cas_n = 1'b1;
  logic        sdr_we_n  = 1'b1;
  logic [1:0]  sdr_ba    = 2'd0;
  logic [12:0] sdr_addr  = 13'd0;
  logic [1:0]  sdr_dqm   = 2'd0;
  logic [15:0] sdr_din   = 16'd0;
  logic [15:0] sdr_dout;
  logic        sdr_den;
  logic [1:0]  rsp_st;
  logic        proto_err;

  typedef struct {
    int          e;
    logic [15:0] d;
  } beat_t;

  beat_t sb[$];
  int    checks  = 0;
  int    errors  = 0;
  int    edge_n  = 0;
  logic  exp_err = 1'b0;

  sdram_rsp_model dut (
    .sdram_clk (sdram_clk),
    .sdram_rst (sdram_rst),
    .sdr_cs_n  (sdr_cs_n),
    .sdr_ras_n (sdr_ras_n),
    .sdr_cas_n (sdr_cas_n),
    .sdr_we_n  (sdr_we_n),
    .sdr_ba    (sdr_ba),
    .sdr_addr  (sdr_addr),
    .sdr_dqm   (sdr_dqm),
    .sdr_din   (sdr_din),
    .sdr_dout  (sdr_dout),
    .sdr_den   (sdr_den),
    .rsp_st    (rsp_st),
    .proto_err (proto_err)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // One clock edge; afterwards the read bus and error flag are compared against the scoreboard.
  task automatic tick();
    beat_t b;
    @(posedge sdram_clk);
    edge_n++;
    #1;
    while (sb.size() > 0 && sb[0].e < edge_n) begin
      check_eq("rd_beat_missed", 32'(edge_n), 32'(sb[0].e));
      b = sb.pop_front();
    end
    if (sb.size() > 0 && sb[0].e == edge_n) begin
      b = sb.pop_front();
      check_eq("rd_den", 32'(sdr_den), 32'd1);
      check_eq("rd_dout", 32'(sdr_dout), 32'(b.d));
    end else begin
      check_eq("idle_den", 32'(sdr_den), 32'd0);
      check_eq("idle_dout", 32'(sdr_dout), 32'd0);
    end
    check_eq("proto_err", 32'(proto_err), 32'(exp_err));
    exp_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] m, input logic err);
    sdr_cs_n = 1'b0;
    {sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
    sdr_ba   = b;
    sdr_addr = a;
    sdr_din  = d;
    sdr_dqm  = m;
    exp_err  = err;
    tick();
    sdr_cs_n = 1'b1;
    {sdr_ras_n, sdr_cas_n, sdr_we_n} = 3'b111;
    sdr_din  = 16'd0;
    sdr_dqm  = 2'd0;
  endtask

  task automatic data_beat(input logic [15:0] d);
    sdr_din = d;
    tick();
    sdr_din = 16'd0;
  endtask

  task automatic expect_beat(input int e, input logic [15:0] d);
    beat_t b;
    b.e = e;
    b.d = d;
    sb.push_back(b);
  endtask

  initial begin
    logic [15:0] a_dat [4];
    logic [15:0] d_dat [4];
    int n;
    a_dat = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    d_dat = '{16'hD000, 16'hD111, 16'hD222, 16'hD333};

    idle(2);
    check_eq("rst_st", 32'(rsp_st), 32'd0);
    sdram_rst = 1'b0;
    idle(1);

    // BL=4 CL=2, write col 4 then read it back
    issue(C_LMR, 2'd0, 13'h022, 16'h0, 2'b00, 1'b0);
    issue(C_ACT, 2'd1, 13'd2, 16'h0, 2'b00, 1'b0);
    issue(C_WR, 2'd1, 13'd4, a_dat[0], 2'b00, 1'b0);
    check_eq("wr_st", 32'(rsp_st), 32'd1);
    for (int k = 1; k < 4; k++) data_beat(a_dat[k]);
    idle(1);
    n = edge_n + 1;
    for (int k = 0; k < 4; k++) expect_beat(n + 2 + k, a_dat[k]);
    issue(C_RD, 2'd1, 13'd4, 16'h0, 2'b00, 1'b0);
    check_eq("rd_st0", 32'(rsp_st), 32'd2);
    for (int k = 1; k < 4; k++) begin
      idle(1);
      check_eq("rd_st", 32'(rsp_st), 32'd2);
    end
    idle(1);
    check_eq("rd_st_end", 32'(rsp_st), 32'd0);
    idle(3);

    // wrapped write at col 6, read from col 4
    issue(C_WR, 2'd1, 13'd6, d_dat[0], 2'b00, 1'b0);
    for (int k = 1; k < 4; k++) data_beat(d_dat[k]);
    idle(1);
    n = edge_n + 1;
    expect_beat(n + 2, d_dat[2]);
    expect_beat(n + 3, d_dat[3]);
    expect_beat(n + 4, d_dat[0]);
    expect_beat(n + 5, d_dat[1]);
    issue(C_RD, 2'd1, 13'd4, 16'h0, 2'b00, 1'b0);
    idle(6);

    // BL=1 CL=2 byte-masked overwrite
    issue(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00, 1'b0);
    issue(C_LMR, 2'd0, 13'h020, 16'h0, 2'b00, 1'b0);
    issue(C_ACT, 2'd1, 13'd2, 16'h0, 2'b00, 1'b0);
    issue(C_WR, 2'd1, 13'd8, 16'h1234, 2'b00, 1'b0);
    check_eq("wr_bl1_st", 32'(rsp_st), 32'd0);
    issue(C_WR, 2'd1, 13'd8, 16'hFFFF, 2'b10, 1'b0);
    n = edge_n + 1;
    expect_beat(n + 2, 16'h12FF);
    issue(C_RD, 2'd1, 13'd8, 16'h0, 2'b00, 1'b0);
    idle(4);

    // BL=8 CL=3 read cut by BURST TERMINATE after two beats
    issue(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00, 1'b0);
    issue(C_LMR, 2'd0, 13'h033, 16'h0, 2'b00, 1'b0);
    issue(C_ACT, 2'd1, 13'd2, 16'h0, 2'b00, 1'b0);
    n = edge_n + 1;
    expect_beat(n + 3, d_dat[2]);
    expect_beat(n + 4, d_dat[3]);
    issue(C_RD, 2'd1, 13'd4, 16'h0, 2'b00, 1'b0);
    idle(1);
    issue(C_BST, 2'd0, 13'd0, 16'h0, 2'b00, 1'b0);
    check_eq("bst_st", 32'(rsp_st), 32'd0);
    idle(8);

    // illegal commands: each must pulse proto_err and change nothing else
    issue(C_RD, 2'd0, 13'd4, 16'h0, 2'b00, 1'b1);
    check_eq("err_rd_st", 32'(rsp_st), 32'd0);
    issue(C_ACT, 2'd1, 13'd3, 16'h0, 2'b00, 1'b1);
    n = edge_n + 1;
    expect_beat(n + 3, d_dat[3]);
    issue(C_RD, 2'd1, 13'd5, 16'h0, 2'b00, 1'b0);
    issue(C_BST, 2'd0, 13'd0, 16'h0, 2'b00, 1'b0);
    idle(4);
    issue(C_REF, 2'd0, 13'd0, 16'h0, 2'b00, 1'b1);
    check_eq("err_ref_st", 32'(rsp_st), 32'd0);
    issue(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00, 1'b0);
    issue(C_REF, 2'd0, 13'd0, 16'h0, 2'b00, 1'b0);
    check_eq("ref_st0", 32'(rsp_st), 32'd3);
    for (int i = 1; i < 7; i++) begin
      if (i == 3) issue(C_RD, 2'd1, 13'd4, 16'h0, 2'b00, 1'b1);
      else        idle(1);
      check_eq("ref_st", 32'(rsp_st), 32'd3);
    end
    idle(1);
    check_eq("ref_st_end", 32'(rsp_st), 32'd0);

    // reset in the middle of a CL=3 burst
    issue(C_ACT, 2'd1, 13'd2, 16'h0, 2'b00, 1'b0);
    n = edge_n + 1;
    expect_beat(n + 3, d_dat[2]);
    issue(C_RD, 2'd1, 13'd4, 16'h0, 2'b00, 1'b0);
    idle(3);
    sdram_rst = 1'b1;
    idle(1);
    sdram_rst = 1'b0;
    check_eq("rst_mid_st", 32'(rsp_st), 32'd0);
    idle(2);
    issue(C_ACT, 2'd1, 13'd2, 16'h0, 2'b00, 1'b0);
    n = edge_n + 1;
    expect_beat(n + 3, d_dat[0]);
    issue(C_RD, 2'd1, 13'd6, 16'h0, 2'b00, 1'b0);
    idle(1);
    check_eq("rst_bl1_st", 32'(rsp_st), 32'd0);
    idle(8);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
